// File: rtl/mesm6_timer.sv
// mesm6_timer -- programmable interval timer on the mesm6 peripheral bus.
//
// A prescaled down-counter with one-shot and periodic (AUTO) modes. It has a
// sticky expiry flag (STATUS.EXP) and a level interrupt irq = EXP & CTRL.IE,
// which feeds one dev_irq bit of mesm6_pic.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   irq        level interrupt request
//   tmr_addr   register address, only [2:0] decoded (chip select is external)
//   tmr_read   read request, held by the master until tmr_done
//   tmr_write  write request, held by the master until tmr_done
//   tmr_rdata  registered read data, valid from the done cycle onward
//   tmr_wdata  write data
//   tmr_done   one-cycle completion pulse
//
// Register map (octal):
//   0 CNT  1 PERIOD  2 CTRL{IE,AUTO,EN}  3 PRESCALE  4 STATUS{EXP} (W1C)
//   5..7 read as zero, writes ignored
module mesm6_timer #(
    parameter int CNT_W = 48,
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             irq,
    input  logic [14:0]      tmr_addr,
    input  logic             tmr_read,
    input  logic             tmr_write,
    output logic [CNT_W-1:0] tmr_rdata,
    input  logic [CNT_W-1:0] tmr_wdata,
    output logic             tmr_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } bus_state_t;

    localparam logic [2:0] A_CNT    = 3'o0;
    localparam logic [2:0] A_PERIOD = 3'o1;
    localparam logic [2:0] A_CTRL   = 3'o2;
    localparam logic [2:0] A_PRE    = 3'o3;
    localparam logic [2:0] A_STATUS = 3'o4;

    bus_state_t       state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pcnt;
    logic             ctrl_en, ctrl_auto, ctrl_ie;
    logic             exp_flag;

    logic [2:0]       reg_sel;
    logic             access, wr_en, rd_en;
    logic             wr_cnt, wr_period, wr_ctrl, wr_pre, wr_status;
    logic             tick, eff_tick, cnt_le1, expire;

    // Upper address bits are decoded by the external chip select.
    logic             addr_unused;
    assign addr_unused = ^tmr_addr[14:3];

    // ------------------------------------------------------------------
    // Bus handshake: a request is performed only on the IDLE->ACK edge.
    // WAIT then holds off until the master drops its request, so a held
    // request is never serviced twice.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmr_done  = 1'b0;
        case (state)
            S_IDLE: if (tmr_read || tmr_write) state_nxt = S_ACK;
            S_ACK: begin
                tmr_done  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: if (!tmr_read && !tmr_write) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign reg_sel   = tmr_addr[2:0];
    assign access    = (state == S_IDLE) && (tmr_read || tmr_write);
    // Write takes priority when both strobes are raised together.
    assign wr_en     = access && tmr_write;
    assign rd_en     = access && tmr_read && !tmr_write;

    assign wr_cnt    = wr_en && (reg_sel == A_CNT);
    assign wr_period = wr_en && (reg_sel == A_PERIOD);
    assign wr_ctrl   = wr_en && (reg_sel == A_CTRL);
    assign wr_pre    = wr_en && (reg_sel == A_PRE);
    assign wr_status = wr_en && (reg_sel == A_STATUS);

    // ------------------------------------------------------------------
    // Prescaler and tick. A CNT or CTRL write in the tick cycle overrides
    // the tick: no decrement, no reload and no expiry for that cycle.
    // ------------------------------------------------------------------
    assign tick     = ctrl_en && (pcnt == prescale);
    assign eff_tick = tick && !wr_cnt && !wr_ctrl;
    assign cnt_le1  = (cnt[CNT_W-1:1] == '0);
    assign expire   = eff_tick && cnt_le1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pcnt <= '0;
        else if (wr_cnt || wr_ctrl || !ctrl_en || tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + PRE_W'(1);
    end

    // ------------------------------------------------------------------
    // Counter / control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (wr_cnt) begin
            cnt <= tmr_wdata;
        end else if (eff_tick) begin
            if (!cnt_le1)       cnt <= cnt - CNT_W'(1);
            else if (ctrl_auto) cnt <= period;
            else                cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en   <= tmr_wdata[0];
            ctrl_auto <= tmr_wdata[1];
            ctrl_ie   <= tmr_wdata[2];
        end else if (expire && !ctrl_auto) begin
            // one-shot stops itself
            ctrl_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period   <= '0;
            prescale <= '0;
        end else begin
            if (wr_period) period   <= tmr_wdata;
            if (wr_pre)    prescale <= tmr_wdata[PRE_W-1:0];
        end
    end

    // A new expiry beats a simultaneous W1C so no event is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         exp_flag <= 1'b0;
        else if (expire)                    exp_flag <= 1'b1;
        else if (wr_status && tmr_wdata[0]) exp_flag <= 1'b0;
    end

    assign irq = exp_flag && ctrl_ie;

    // ------------------------------------------------------------------
    // Read data register, updated only on a performed read
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_rdata <= '0;
        end else if (rd_en) begin
            case (reg_sel)
                A_CNT:    tmr_rdata <= cnt;
                A_PERIOD: tmr_rdata <= period;
                A_CTRL:   tmr_rdata <= CNT_W'({ctrl_ie, ctrl_auto, ctrl_en});
                A_PRE:    tmr_rdata <= CNT_W'(prescale);
                A_STATUS: tmr_rdata <= CNT_W'(exp_flag);
                default:  tmr_rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mesm6_timer.sv
// Self-checking bench for mesm6_timer. Every bus transaction pushes its
// expected result into a scoreboard queue; a monitor pops one entry per done
// pulse and compares read data.
module tb_mesm6_timer;

    localparam int CNT_W = 48;
    localparam int PRE_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             irq;
    logic [14:0]      tmr_addr = '0;
    logic             tmr_read = 1'b0;
    logic             tmr_write = 1'b0;
    logic [CNT_W-1:0] tmr_rdata;
    logic [CNT_W-1:0] tmr_wdata = '0;
    logic             tmr_done;

    mesm6_timer #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .tmr_addr  (tmr_addr),
        .tmr_read  (tmr_read),
        .tmr_write (tmr_write),
        .tmr_rdata (tmr_rdata),
        .tmr_wdata (tmr_wdata),
        .tmr_done  (tmr_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;

    typedef struct {
        bit          rd;
        logic [47:0] val;
        string       tag;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: one entry per done pulse.
    always @(negedge clk) begin
        if (reset && tmr_done) begin
            done_cnt++;
            check("done_has_pending", 48'(sb_q.size() != 0), 48'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                if (mon_e.rd) check(mon_e.tag, tmr_rdata, mon_e.val);
            end
        end
    end

    task automatic bus(input bit is_wr, input logic [14:0] a, input logic [47:0] d,
                       input logic [47:0] e, input string tag);
        bit got;
        @(posedge clk); #1;
        tmr_addr  = a;
        tmr_wdata = d;
        tmr_read  = !is_wr;
        tmr_write = is_wr;
        sb_q.push_back('{rd: !is_wr, val: e, tag: tag});
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tmr_done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 48'(got), 48'd1);
        @(posedge clk); #1;
        tmr_read  = 1'b0;
        tmr_write = 1'b0;
        if (!got) sb_q.delete();
    endtask

    task automatic wr_reg(input logic [14:0] a, input logic [47:0] d, input string tag);
        bus(1'b1, a, d, 48'd0, tag);
    endtask

    task automatic rd_chk(input logic [14:0] a, input logic [47:0] e, input string tag);
        bus(1'b0, a, 48'd0, e, tag);
    endtask

    // Wait (bounded) for irq high; returns the index of the edge that raised it.
    task automatic wait_irq(input string tag, output int at);
        int n;
        n = 0;
        while (!irq && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_irq_seen"}, 48'(irq), 48'd1);
        at = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n, r0, r1, r2;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_irq", 48'(irq), 48'd0);
        check("rst_done", 48'(tmr_done), 48'd0);
        check("rst_rdata", tmr_rdata, 48'd0);
        @(negedge clk) reset = 1'b1;
        d0 = done_cnt;
        for (int a = 0; a < 8; a++) rd_chk(15'(a), 48'd0, $sformatf("rst_rd%0d", a));
        check("rst_done_cnt", 48'(done_cnt - d0), 48'd8);
        check("rst_irq_after", 48'(irq), 48'd0);

        // ---------------- one-shot ----------------
        wr_reg(15'o3, 48'd0, "os_pre");
        wr_reg(15'o0, 48'd3, "os_cnt");
        wr_reg(15'o2, 48'd5, "os_ctrl");
        // Ticks on the 1st, 2nd and 3rd edges after the CTRL write edge.
        n = 0;
        while (!irq && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("os_irq_latency", 48'(n), 48'd3);
        rd_chk(15'o2, 48'd4, "os_ctrl_rd");
        rd_chk(15'o0, 48'd0, "os_cnt_rd");
        rd_chk(15'o4, 48'd1, "os_status_rd");
        wr_reg(15'o4, 48'd1, "os_w1c");
        check("os_irq_cleared", 48'(irq), 48'd0);
        rd_chk(15'o4, 48'd0, "os_status_clr");

        // ---------------- periodic ----------------
        wr_reg(15'o1, 48'd4, "per_period");
        wr_reg(15'o3, 48'd1, "per_pre");
        wr_reg(15'o0, 48'd4, "per_cnt");
        wr_reg(15'o2, 48'd7, "per_ctrl");
        wait_irq("per0", r0);
        wr_reg(15'o4, 48'd1, "per_w1c0");
        check("per_irq_low0", 48'(irq), 48'd0);
        wait_irq("per1", r1);
        check("per_interval1", 48'(r1 - r0), 48'd8);
        wr_reg(15'o4, 48'd1, "per_w1c1");
        check("per_irq_low1", 48'(irq), 48'd0);
        wait_irq("per2", r2);
        check("per_interval2", 48'(r2 - r1), 48'd8);

        // ---------------- W1C coinciding with expiry ----------------
        // Next expiry edge is r2+8; launch the W1C so it is sampled there.
        while (cyc != r2 + 6) @(negedge clk);
        wr_reg(15'o4, 48'd1, "race_w1c");
        check("race_irq", 48'(irq), 48'd1);
        rd_chk(15'o4, 48'd1, "race_status");

        wr_reg(15'o2, 48'd0, "stop_ctrl");
        wr_reg(15'o4, 48'd1, "stop_w1c");
        check("stop_irq", 48'(irq), 48'd0);

        // ---------------- held write ----------------
        d0 = done_cnt;
        @(posedge clk); #1;
        tmr_addr  = 15'o0;
        tmr_wdata = 48'd100;
        tmr_write = 1'b1;
        sb_q.push_back('{rd: 1'b0, val: 48'd0, tag: "hold_wr"});
        repeat (6) @(posedge clk);
        #1 tmr_write = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_done_cnt", 48'(done_cnt - d0), 48'd1);
        rd_chk(15'o0, 48'd100, "hold_cnt_rd");

        // ---------------- unmapped address ----------------
        wr_reg(15'o6, 48'h1234, "nomap_wr");
        rd_chk(15'o6, 48'd0, "nomap_rd");
        rd_chk(15'o0, 48'd100, "nomap_cnt");
        rd_chk(15'o1, 48'd4, "nomap_period");
        rd_chk(15'o2, 48'd0, "nomap_ctrl");
        rd_chk(15'o3, 48'd1, "nomap_pre");
        rd_chk(15'o4, 48'd0, "nomap_status");

        // ---------------- reset mid-count ----------------
        wr_reg(15'o3, 48'd0, "mr_pre");
        wr_reg(15'o0, 48'd50, "mr_cnt");
        wr_reg(15'o2, 48'd5, "mr_ctrl");
        rd_chk(15'o1, 48'd4, "mr_period_rd");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mr_rdata", tmr_rdata, 48'd0);
        check("mr_irq", 48'(irq), 48'd0);
        check("mr_done", 48'(tmr_done), 48'd0);
        @(negedge clk) reset = 1'b1;
        repeat (5) @(negedge clk);
        for (int a = 0; a < 5; a++) rd_chk(15'(a), 48'd0, $sformatf("mr_rd%0d", a));
        check("mr_irq_after", 48'(irq), 48'd0);

        check("sb_empty", 48'(sb_q.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
